filter_mac_5x5: RTL



---
 rtl/filter_mac_5x5.sv | 109 ++++++++++
 1 files changed

// File: rtl/filter_mac_5x5.sv
// Sequential 5x5 signed fixed-point MAC: snapshots filter and window on start, one product per clock.
// Optional macro FILTER_MAC_RELU_EN clamps negative results to zero in the output stage.
module filter_mac_5x5 #(
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4:0][4:0][15:0]   filter,
  input  logic [4:0][4:0][15:0]   window,
  output logic signed [15:0]      result,
  output logic                    done,
  output logic                    busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MAC    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-16){1'b0}}, 16'h7fff};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-16){1'b1}}, 16'h8000};

  logic [1:0]               state;
  logic [2:0]               row;
  logic [2:0]               col;
  logic signed [ACC_W-1:0]  acc;
  logic [4:0][4:0][15:0]    f_reg;
  logic [4:0][4:0][15:0]    w_reg;

  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [15:0]       sat_val;
  logic signed [15:0]       out_val;

  assign prod    = $signed(f_reg[row][col]) * $signed(w_reg[row][col]);
  assign shifted = acc >>> FRAC_BITS;

  always_comb begin
    sat_val = shifted[15:0];
    if (shifted > SAT_MAX)
      sat_val = 16'sh7fff;
    else if (shifted < SAT_MIN)
      sat_val = -16'sh8000;
  end

`ifdef FILTER_MAC_RELU_EN
  assign out_val = sat_val[15] ? 16'sd0 : sat_val;
`else
  assign out_val = sat_val;
`endif

  // Operand copies need no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      f_reg <= filter;
      w_reg <= window;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= 16'sd0;
      done   <= 1'b0;
      busy   <= 1'b0;
      acc    <= '0;
      row    <= 3'd0;
      col    <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            row   <= 3'd0;
            col   <= 3'd0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
          // Row-major walk; the last tap moves straight to the output stage.
          if (col == 3'd4) begin
            col <= 3'd0;
            if (row == 3'd4)
              state <= FINISH;
            else
              row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        FINISH: begin
          result <= out_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
